gray_count_checker: RTL and testbench

Receive-side companion to gray_counter. Samples a Gray-coded count each enabled cycle, decodes it to binary through a 2-stage pipeline, and checks that consecutive samples advance by exactly +1 (mod 2^DATA_WIDTH). Reports lock status, per-sample step errors and a saturating error count. Used at the consuming end of Gray-coded pointers/counters, and as a self-checking monitor in benches.

---
 rtl/gray_count_checker.sv | 164 ++++++++++++++++
 tb/tb_gray_count_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_count_checker.sv
// gray_count_checker
//   Receive-side companion to gray_counter. Each enabled cycle a Gray-coded
//   count is sampled, decoded to binary through a two-stage pipeline, and
//   checked for an exact +1 step (mod 2^DATA_WIDTH) against the previous
//   sample. The block tracks lock status, flags step errors and keeps a
//   saturating error count.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         gray_in is valid this cycle
//   gray_in    Gray-coded count [DATA_WIDTH]
//   err_clr    synchronous clear of err_count
//   bin_out    decoded binary value [DATA_WIDTH] (holds between samples)
//   bin_valid  one-cycle pulse per decoded sample
//   step_err   one-cycle pulse: was locked and the sample was not prev+1
//   locked     checker is in the LOCKED state
//   err_count  saturating count of step_err pulses [ERR_WIDTH]
module gray_count_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] gray_in,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  bin_valid,
    output logic                  step_err,
    output logic                  locked,
    output logic [ERR_WIDTH-1:0]  err_count
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0]  ERR_ONE   = ERR_WIDTH'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      LOCK_LAST = CNT_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0]      LOCK_FULL = CNT_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] g1;
    logic                  v1;
    logic [DATA_WIDTH-1:0] bin_d;
    logic [DATA_WIDTH-1:0] prev, prev_nxt;
    logic [CNT_W-1:0]      good_cnt, good_cnt_nxt;
    logic                  good_step;
    logic                  step_err_nxt;
    logic [ERR_WIDTH-1:0]  err_nxt;

    // Stage 1: capture the Gray sample and its valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= en;
            if (en) begin
                g1 <= gray_in;
            end
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it, which is the same as the MSB-down prefix XOR chain.
    always_comb begin
        bin_d = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            bin_d[i] = ^(g1 >> i);
        end
    end

    // Wraps naturally: all-ones + 1 truncates to zero.
    assign good_step = (bin_d == prev + DATA_ONE);

    // Checker next-state, evaluated on the stage-2 sample in the same cycle
    // it is registered into bin_out.
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        prev_nxt     = prev;
        step_err_nxt = 1'b0;
        if (v1) begin
            prev_nxt = bin_d;
            unique case (state)
                IDLE: begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = '0;
                end
                ACQUIRE: begin
                    if (good_step) begin
                        if (good_cnt == LOCK_LAST) begin
                            state_nxt    = LOCKED;
                            good_cnt_nxt = LOCK_FULL;
                        end else begin
                            good_cnt_nxt = good_cnt + CNT_ONE;
                        end
                    end else begin
                        good_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!good_step) begin
                        step_err_nxt = 1'b1;
                        state_nxt    = ACQUIRE;
                        good_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    good_cnt_nxt = '0;
                end
            endcase
        end
    end

    // A clear that coincides with a new error leaves exactly that error.
    always_comb begin
        err_nxt = err_count;
        if (step_err_nxt) begin
            if (err_clr) begin
                err_nxt = ERR_ONE;
            end else if (err_count != '1) begin
                err_nxt = err_count + ERR_ONE;
            end
        end else if (err_clr) begin
            err_nxt = '0;
        end
    end

    // Stage 2 and checker state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            good_cnt  <= '0;
            prev      <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_cnt_nxt;
            prev      <= prev_nxt;
            bin_valid <= v1;
            if (v1) begin
                bin_out <= bin_d;
            end
            step_err  <= step_err_nxt;
            locked    <= (state_nxt == LOCKED);
            err_count <= err_nxt;
        end
    end

endmodule

// File: tb/tb_gray_count_checker.sv
// tb_gray_count_checker
//   Randomised and directed stimulus against a streak-counting reference
//   model. Expected per-sample results are queued by the driver and popped
//   by an independent monitor whenever bin_valid is seen.
module tb_gray_count_checker;

    localparam int DW  = 8;
    localparam int LC  = 4;
    localparam int EW  = 2;
    localparam int MOD = 1 << DW;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] gray_in;
    logic          err_clr;
    logic [DW-1:0] bin_out;
    logic          bin_valid;
    logic          step_err;
    logic          locked;
    logic [EW-1:0] err_count;

    gray_count_checker #(
        .DATA_WIDTH (DW),
        .LOCK_COUNT (LC),
        .ERR_WIDTH  (EW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .gray_in   (gray_in),
        .err_clr   (err_clr),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_err  (step_err),
        .locked    (locked),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nbad = 0;

    typedef struct {
        int            cyc;
        logic [DW-1:0] b;
        logic          step;
    } exp_t;
    exp_t q[$];

    // Reference model: a sample stream with a running count of consecutive
    // +1 steps; locked means that streak has reached LC.
    bit            m_have;
    int            m_prev;
    int            m_streak;
    int            m_err;
    bit            p_v;
    int            p_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] to_gray(input logic [DW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic void model_reset();
        m_have   = 1'b0;
        m_prev   = 0;
        m_streak = 0;
        m_err    = 0;
        p_v      = 1'b0;
        p_b      = 0;
    endfunction

    // Settle the sample issued last cycle; it is judged at the coming edge,
    // alongside this cycle's err_clr.
    task automatic model_step(input bit clr);
        exp_t e;
        bit   st;
        st = 1'b0;
        if (p_v) begin
            if (!m_have) begin
                m_have   = 1'b1;
                m_streak = 0;
            end else if (p_b == (m_prev + 1) % MOD) begin
                m_streak++;
            end else begin
                st       = (m_streak >= LC);
                m_streak = 0;
            end
            m_prev = p_b;
            e.cyc  = cyc + 1;
            e.b    = DW'(p_b);
            e.step = st;
            q.push_back(e);
        end
        if (st) m_err = clr ? 1 : (m_err == EMAX ? EMAX : m_err + 1);
        else if (clr) m_err = 0;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic drive(input bit e, input int v, input bit clr);
        model_step(clr);
        en      = e;
        gray_in = to_gray(DW'(v % MOD));
        err_clr = clr;
        p_v     = e;
        p_b     = v % MOD;
        @(posedge clk);
        #1;
        chk("locked", {31'd0, locked}, {31'd0, (m_have && m_streak >= LC)});
        chk("err_count", 32'(err_count), 32'(m_err));
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {20'd0, bin_out, bin_valid, step_err, locked, err_count}, 32'd0);
        q.delete();
        model_reset();
        en      = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per bin_valid and checks arrival cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bin_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", 32'(cyc), 32'(e.cyc));
                    chk("bin_out", 32'(bin_out), 32'(e.b));
                    chk("step_err", {31'd0, step_err}, {31'd0, e.step});
                end
            end else begin
                chk("idle_step_err", {31'd0, step_err}, 32'd0);
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    chk("missing_valid", 32'(cyc), 32'(q[0].cyc));
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int r;
        bit e;
        rst_n   = 1'b0;
        en      = 1'b0;
        gray_in = '0;
        err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {20'd0, bin_out, bin_valid, step_err, locked, err_count}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Straight count from zero.
        for (int i = 0; i <= 20; i++) drive(1'b1, i, 1'b0);
        do_reset();

        // Wrap through all-ones.
        for (int i = 250; i <= 260; i++) drive(1'b1, i, 1'b0);
        do_reset();

        // Skip injected while locked, then relock.
        for (int i = 0; i <= 10; i++) drive(1'b1, i, 1'b0);
        for (int i = 13; i <= 20; i++) drive(1'b1, i, 1'b0);
        do_reset();

        // Repeated value while locked.
        for (int i = 0; i <= 7; i++) drive(1'b1, i, 1'b0);
        for (int i = 7; i <= 12; i++) drive(1'b1, i, 1'b0);
        do_reset();

        // Every-other-cycle enable.
        for (int i = 0; i <= 15; i++) begin
            drive(1'b1, i, 1'b0);
            drive(1'b0, int'($urandom_range(0, MOD - 1)), 1'b0);
        end
        do_reset();

        // Saturation: eight runs of five, each run after the first opens
        // with a skip taken while locked.
        v = 0;
        for (int run = 0; run < 8; run++) begin
            for (int k = 0; k < 5; k++) begin
                drive(1'b1, v, 1'b0);
                v++;
            end
            v += 2;
        end
        drive(1'b1, v + 5, 1'b0);
        drive(1'b1, v + 6, 1'b1);
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b0);

        // Mid-stream reset with samples still in the pipeline.
        for (int i = 40; i <= 46; i++) drive(1'b1, i, 1'b0);
        do_reset();

        // Random traffic: gaps, jumps, repeats, clears, occasional reset.
        v = int'($urandom_range(0, MOD - 1));
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            e = (r < 80);
            if (e) begin
                if (r < 5) v = int'($urandom_range(0, MOD - 1));
                else if (r >= 8) v = (v + 1) % MOD;
            end
            drive(e, v, ($urandom_range(0, 49) == 0));
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        repeat (3) drive(1'b0, 0, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
